// File: rtl/fp_mul_sequencer.sv
// Issue/capture stage for the sequential FP multiplier: holds operands, pulses start, captures result.
// Optional local handling of zero/inf/NaN operands when FP_MUL_SPECIAL_BYPASS_EN is defined.
//
// state | meaning
// IDLE  | ready for a new operand pair
// ISSUE | start pulse to the multiplier, timeout counter cleared
// WAIT  | waiting for multiplier done or timeout
// HOLD  | result presented, waiting for consumer
module fp_mul_sequencer #(
  parameter int SIZE     = 32,
  parameter int EXPONENT = 5 + ($clog2(SIZE) - 4) * 3,
  parameter int FRACTION = SIZE - EXPONENT - 1,
  parameter int TIMEOUT  = 4 * SIZE + 16
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_en,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [SIZE-1:0] i_A,
  input  logic [SIZE-1:0] i_B,
  output logic [SIZE-1:0] o_mul_A,
  output logic [SIZE-1:0] o_mul_B,
  output logic            o_mul_start,
  input  logic [SIZE-1:0] i_mul_result,
  input  logic            i_mul_done,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [SIZE-1:0] o_result,
  output logic            o_error,
  output logic            o_special,
  output logic            o_busy
);

  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [SIZE-1:0] CANON_NAN = {1'b0, {EXPONENT{1'b1}}, 1'b1, {(FRACTION-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic              byp_hit;
  logic [SIZE-1:0]   byp_result;

`ifdef FP_MUL_SPECIAL_BYPASS_EN
  logic [EXPONENT-1:0] exp_a, exp_b;
  logic [FRACTION-1:0] frac_a, frac_b;
  logic                zero_a, zero_b, inf_a, inf_b, nan_a, nan_b, sign_p;

  assign exp_a  = i_A[SIZE-2 -: EXPONENT];
  assign exp_b  = i_B[SIZE-2 -: EXPONENT];
  assign frac_a = i_A[FRACTION-1:0];
  assign frac_b = i_B[FRACTION-1:0];
  // Denormals have a zero exponent and are flushed to zero here.
  assign zero_a = (exp_a == '0);
  assign zero_b = (exp_b == '0);
  assign inf_a  = (&exp_a) && (frac_a == '0);
  assign inf_b  = (&exp_b) && (frac_b == '0);
  assign nan_a  = (&exp_a) && (frac_a != '0);
  assign nan_b  = (&exp_b) && (frac_b != '0);
  assign sign_p = i_A[SIZE-1] ^ i_B[SIZE-1];

  assign byp_hit = zero_a | zero_b | inf_a | inf_b | nan_a | nan_b;

  always_comb begin
    byp_result = CANON_NAN;
    if (nan_a || nan_b || (inf_a && zero_b) || (inf_b && zero_a))
      byp_result = CANON_NAN;
    else if (inf_a || inf_b)
      byp_result = {sign_p, {EXPONENT{1'b1}}, {FRACTION{1'b0}}};
    else
      byp_result = {sign_p, {(SIZE-1){1'b0}}};
  end
`else
  assign byp_hit    = 1'b0;
  assign byp_result = CANON_NAN;
`endif

  assign o_busy = (state != IDLE);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      o_ready     <= 1'b0;
      o_mul_A     <= '0;
      o_mul_B     <= '0;
      o_mul_start <= 1'b0;
      o_valid     <= 1'b0;
      o_result    <= '0;
      o_error     <= 1'b0;
      o_special   <= 1'b0;
    end else if (i_en) begin
      case (state)
        IDLE: begin
          o_ready <= 1'b1;
          if (i_valid && o_ready) begin
            o_mul_A   <= i_A;
            o_mul_B   <= i_B;
            o_ready   <= 1'b0;
            o_error   <= 1'b0;
            o_special <= byp_hit;
            if (byp_hit) begin
              o_result <= byp_result;
              o_valid  <= 1'b1;
              state    <= HOLD;
            end else begin
              o_mul_start <= 1'b1;
              state       <= ISSUE;
            end
          end
        end
        ISSUE: begin
          o_mul_start <= 1'b0;
          cnt         <= '0;
          state       <= WAIT;
        end
        WAIT: begin
          // A done arriving on the timeout cycle still delivers the real result.
          if (i_mul_done) begin
            o_result <= i_mul_result;
            o_error  <= 1'b0;
            o_valid  <= 1'b1;
            state    <= HOLD;
          end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
            o_result <= CANON_NAN;
            o_error  <= 1'b1;
            o_valid  <= 1'b1;
            state    <= HOLD;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        HOLD: begin
          if (i_ready) begin
            o_valid <= 1'b0;
            o_ready <= 1'b1;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_mul_sequencer.sv
// Directed bench for fp_mul_sequencer with a fixed-latency multiplier stub.
module tb_fp_mul_sequencer;

  localparam int TIMEOUT = 144;
  localparam int MUL_LAT = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b1;
  logic        i_valid = 1'b0;
  logic        o_ready;
  logic [31:0] i_A = '0, i_B = '0;
  logic [31:0] o_mul_A, o_mul_B;
  logic        o_mul_start;
  logic [31:0] mul_result = '0;
  logic        model_done = 1'b0;
  logic        stray_done = 1'b0;
  logic        mul_done;
  logic        o_valid;
  logic        i_ready = 1'b0;
  logic [31:0] o_result;
  logic        o_error, o_special, o_busy;

  logic        mul_en = 1'b0;
  logic [31:0] mul_rsp = '0;
  int          mul_timer = 0;
  int          starts = 0;
  int          n_checks = 0;
  int          n_fail = 0;

  assign mul_done = model_done | stray_done;

  fp_mul_sequencer dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en),
    .i_valid(i_valid), .o_ready(o_ready),
    .i_A(i_A), .i_B(i_B),
    .o_mul_A(o_mul_A), .o_mul_B(o_mul_B), .o_mul_start(o_mul_start),
    .i_mul_result(mul_result), .i_mul_done(mul_done),
    .o_valid(o_valid), .i_ready(i_ready), .o_result(o_result),
    .o_error(o_error), .o_special(o_special), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  // Multiplier stub: done pulse MUL_LAT negedges after it sees start.
  always @(negedge clk) begin
    model_done = 1'b0;
    if (mul_timer > 0) begin
      mul_timer--;
      if (mul_timer == 0) begin
        model_done = 1'b1;
        mul_result = mul_rsp;
      end
    end
    if (o_mul_start === 1'b1) begin
      starts++;
      if (mul_en) mul_timer = MUL_LAT;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_accept(input logic [31:0] a, input logic [31:0] b);
    int n = 0;
    while (o_ready !== 1'b1 && n < 50) begin
      step();
      n++;
    end
    i_A = a;
    i_B = b;
    i_valid = 1'b1;
    step();
    i_valid = 1'b0;
  endtask

  task automatic wait_valid(input int bound, output int cycles, output bit ok);
    cycles = 0;
    ok = 1'b0;
    while (cycles < bound) begin
      if (o_valid === 1'b1) begin
        ok = 1'b1;
        return;
      end
      step();
      cycles++;
    end
    ok = (o_valid === 1'b1);
  endtask

  task automatic drain();
    i_ready = 1'b1;
    step();
    i_ready = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    n_checks++;
    if ({o_ready, o_valid, o_mul_start, o_error, o_special, o_busy} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got %b want 000000", {o_ready, o_valid, o_mul_start, o_error, o_special, o_busy});
    end
    n_checks++;
    if ({o_mul_A, o_mul_B, o_result} !== 96'h0) begin
      n_fail++;
      $display("FAIL reset_data: got %h %h %h want zeros", o_mul_A, o_mul_B, o_result);
    end
    step();
    rst_n = 1'b1;
    step();
    step();
    n_checks++;
    if (o_ready !== 1'b1 || o_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle: ready=%b busy=%b want ready=1 busy=0", o_ready, o_busy);
    end
  endtask

  task automatic test_basic();
    int cyc;
    bit ok;
    int s0 = starts;
    mul_en = 1'b1;
    mul_rsp = 32'h40C00000;
    do_accept(32'h40000000, 32'h40400000);
    wait_valid(100, cyc, ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL basic_valid: o_valid=%b after %0d cycles want 1", o_valid, cyc);
    end
    n_checks++;
    if (o_result !== 32'h40C00000 || o_error !== 1'b0 || o_special !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_result: got %h err=%b spc=%b want 40c00000 0 0", o_result, o_error, o_special);
    end
    n_checks++;
    if (starts - s0 !== 1) begin
      n_fail++;
      $display("FAIL basic_starts: got %0d start pulses want 1", starts - s0);
    end
    n_checks++;
    if (o_mul_A !== 32'h40000000 || o_mul_B !== 32'h40400000) begin
      n_fail++;
      $display("FAIL basic_operands: got %h %h want 40000000 40400000", o_mul_A, o_mul_B);
    end
  endtask

  task automatic test_hold_stall();
    int bad = 0;
    i_A = 32'h3F800000;
    i_B = 32'h3F800000;
    i_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      if (o_valid !== 1'b1 || o_ready !== 1'b0 || o_result !== 32'h40C00000 ||
          o_mul_A !== 32'h40000000 || o_mul_B !== 32'h40400000)
        bad++;
    end
    i_valid = 1'b0;
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL hold_stable: %0d unstable cycles of 10, want 0", bad);
    end
    drain();
    n_checks++;
    if (o_valid !== 1'b0 || o_ready !== 1'b1 || o_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL hold_release: valid=%b ready=%b busy=%b want 0 1 0", o_valid, o_ready, o_busy);
    end
  endtask

  task automatic test_enable();
    int cyc;
    bit ok;
    int s0 = starts;
    mul_en = 1'b1;
    mul_rsp = 32'h41000000;
    en = 1'b0;
    i_A = 32'h40000000;
    i_B = 32'h40800000;
    i_valid = 1'b1;
    repeat (3) step();
    n_checks++;
    if (o_busy !== 1'b0 || starts != s0) begin
      n_fail++;
      $display("FAIL enable_hold: busy=%b starts=%0d want 0 0", o_busy, starts - s0);
    end
    en = 1'b1;
    step();
    i_valid = 1'b0;
    n_checks++;
    if (o_busy !== 1'b1 || o_mul_start !== 1'b1) begin
      n_fail++;
      $display("FAIL enable_accept: busy=%b start=%b want 1 1", o_busy, o_mul_start);
    end
    wait_valid(100, cyc, ok);
    n_checks++;
    if (!ok || o_result !== 32'h41000000) begin
      n_fail++;
      $display("FAIL enable_result: valid=%b got %h want 41000000", o_valid, o_result);
    end
    drain();
  endtask

  task automatic test_timeout();
    int cyc;
    bit ok;
    mul_en = 1'b0;
    do_accept(32'h40000000, 32'h40400000);
    n_checks++;
    if (o_mul_start !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_start: start=%b want 1", o_mul_start);
    end
    wait_valid(400, cyc, ok);
    n_checks++;
    if (!ok || cyc != TIMEOUT + 1) begin
      n_fail++;
      $display("FAIL timeout_latency: valid=%b after %0d edges want %0d", o_valid, cyc, TIMEOUT + 1);
    end
    n_checks++;
    if (o_result !== 32'h7FC00000 || o_error !== 1'b1 || o_special !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_result: got %h err=%b spc=%b want 7fc00000 1 0", o_result, o_error, o_special);
    end
    drain();
  endtask

  task automatic test_specials();
    logic [31:0] va [6] = '{32'h00000000, 32'h7F800000, 32'hFF800000, 32'hFFC00001, 32'h00000001, 32'h7F800000};
    logic [31:0] vb [6] = '{32'hC0400000, 32'h00000000, 32'h40000000, 32'h3F800000, 32'hC0000000, 32'hFF800000};
    logic [31:0] vr [6] = '{32'h80000000, 32'h7FC00000, 32'hFF800000, 32'h7FC00000, 32'h80000000, 32'hFF800000};
    int cyc;
    bit ok;
    int s0;
    logic exp_spc;
    int exp_starts;
`ifdef FP_MUL_SPECIAL_BYPASS_EN
    exp_spc = 1'b1;
    exp_starts = 0;
`else
    exp_spc = 1'b0;
    exp_starts = 1;
`endif
    mul_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      s0 = starts;
      mul_rsp = vr[i];
      do_accept(va[i], vb[i]);
`ifdef FP_MUL_SPECIAL_BYPASS_EN
      n_checks++;
      if (o_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL special_latency[%0d]: valid=%b one cycle after accept want 1", i, o_valid);
      end
`endif
      wait_valid(100, cyc, ok);
      n_checks++;
      if (!ok || o_result !== vr[i] || o_error !== 1'b0) begin
        n_fail++;
        $display("FAIL special_result[%0d]: valid=%b got %h err=%b want %h 0", i, o_valid, o_result, o_error, vr[i]);
      end
      step();
      n_checks++;
      if (o_special !== exp_spc || starts - s0 != exp_starts) begin
        n_fail++;
        $display("FAIL special_path[%0d]: spc=%b starts=%0d want %b %0d", i, o_special, starts - s0, exp_spc, exp_starts);
      end
      drain();
    end
  endtask

  task automatic test_reset_mid();
    int s0;
    mul_en = 1'b0;
    do_accept(32'h40000000, 32'h40400000);
    repeat (5) step();
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({o_ready, o_valid, o_mul_start, o_error, o_special, o_busy} !== 6'b0 ||
        {o_mul_A, o_mul_B, o_result} !== 96'h0) begin
      n_fail++;
      $display("FAIL reset_mid: flags=%b A=%h B=%h R=%h want all 0",
               {o_ready, o_valid, o_mul_start, o_error, o_special, o_busy}, o_mul_A, o_mul_B, o_result);
    end
    step();
    rst_n = 1'b1;
    step();
    step();
    n_checks++;
    if (o_ready !== 1'b1 || o_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_idle: ready=%b busy=%b want 1 0", o_ready, o_busy);
    end
    s0 = starts;
    stray_done = 1'b1;
    step();
    stray_done = 1'b0;
    step();
    n_checks++;
    if (o_valid !== 1'b0 || o_busy !== 1'b0 || starts != s0) begin
      n_fail++;
      $display("FAIL stray_done: valid=%b busy=%b want 0 0", o_valid, o_busy);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_hold_stall();
    test_enable();
    test_timeout();
    test_specials();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
